// File: rtl/serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serializer                                                   |
// | Description : Parallel-to-serial converter. The word is sent MSB first,    |
// |               with a programmable bit count (0 = full word). Back-to-back  |
// |               words stream with no idle cycle.                             |
// |               Optional macro SERIALIZER_PREFETCH_EN adds a one-word        |
// |               holding register, so that a word can be accepted mid-shift.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module serializer #(
  parameter  int DATA_W = 16,
  localparam int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  localparam logic [MOD_W:0] FULL_LEN = (MOD_W+1)'(DATA_W);
  localparam logic [MOD_W:0] CNT_ONE  = (MOD_W+1)'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   shift_reg, shift_nxt;
  logic [MOD_W:0]      cnt, cnt_nxt;
  logic [MOD_W:0]      last_idx, last_idx_nxt;
  logic                ser_bit, ser_bit_nxt;
  logic                ser_val, ser_val_nxt;

  logic                is_last;
  logic                accept;
  logic                busy;
  logic [MOD_W:0]      new_last;

  // Word selected for loading into the shift register this cycle
  logic                load_en;
  logic [DATA_W-1:0]   load_word;
  logic [MOD_W:0]      load_last;

`ifdef SERIALIZER_PREFETCH_EN
  logic                hold_full, hold_full_nxt;
  logic [DATA_W-1:0]   hold_data, hold_data_nxt;
  logic [MOD_W:0]      hold_last, hold_last_nxt;
`endif

  // cnt indexes the bit currently on ser_data_o; last_idx = len-1
  assign is_last  = (cnt == last_idx);
  assign new_last = ((data_mod_i == '0) ? FULL_LEN : {1'b0, data_mod_i}) - CNT_ONE;

`ifdef SERIALIZER_PREFETCH_EN
  assign busy = hold_full;
`else
  assign busy = (state == SHIFT) && !is_last;
`endif

  assign accept         = data_val_i && !busy;
  assign busy_o         = busy;
  assign ser_data_o     = ser_bit;
  assign ser_data_val_o = ser_val;

  // Next-state and datapath decode; a load always presents the new MSB next cycle
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_reg;
    cnt_nxt      = cnt;
    last_idx_nxt = last_idx;
    ser_bit_nxt  = 1'b0;
    ser_val_nxt  = 1'b0;
    load_en      = 1'b0;
    load_word    = data_i;
    load_last    = new_last;
`ifdef SERIALIZER_PREFETCH_EN
    hold_full_nxt = hold_full;
    hold_data_nxt = hold_data;
    hold_last_nxt = hold_last;
`endif

    unique case (state)
      IDLE: begin
        load_en = accept;
      end
      SHIFT: begin
        if (is_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
`ifdef SERIALIZER_PREFETCH_EN
          if (hold_full) begin
            load_en       = 1'b1;
            load_word     = hold_data;
            load_last     = hold_last;
            hold_full_nxt = 1'b0;
          end else begin
            load_en = accept;
          end
`else
          load_en = accept;
`endif
        end else begin
          cnt_nxt     = cnt + CNT_ONE;
          shift_nxt   = {shift_reg[DATA_W-2:0], 1'b0};
          ser_bit_nxt = shift_reg[DATA_W-2];
          ser_val_nxt = 1'b1;
`ifdef SERIALIZER_PREFETCH_EN
          if (accept) begin
            hold_full_nxt = 1'b1;
            hold_data_nxt = data_i;
            hold_last_nxt = new_last;
          end
`endif
        end
      end
    endcase

    if (load_en) begin
      state_nxt    = SHIFT;
      shift_nxt    = load_word;
      cnt_nxt      = '0;
      last_idx_nxt = load_last;
      ser_bit_nxt  = load_word[DATA_W-1];
      ser_val_nxt  = 1'b1;
    end
  end

  // State and datapath registers; reset overrides any word offered in the same cycle
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      last_idx  <= '0;
      ser_bit   <= 1'b0;
      ser_val   <= 1'b0;
`ifdef SERIALIZER_PREFETCH_EN
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_last <= '0;
`endif
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      cnt       <= cnt_nxt;
      last_idx  <= last_idx_nxt;
      ser_bit   <= ser_bit_nxt;
      ser_val   <= ser_val_nxt;
`ifdef SERIALIZER_PREFETCH_EN
      hold_full <= hold_full_nxt;
      hold_data <= hold_data_nxt;
      hold_last <= hold_last_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_serializer                                                |
// | Description : Self-checking bench for serializer (DATA_W = 16). Honours    |
// |               SERIALIZER_PREFETCH_EN for the busy_o expectations.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_serializer;

  localparam int DW = 16;
  localparam int MW = 4;

`ifdef SERIALIZER_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          srst = 1'b0;
  logic [DW-1:0] data = '0;
  logic [MW-1:0] mod = '0;
  logic          val = 1'b0;
  logic          ser;
  logic          ser_val;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serializer #(.DATA_W(DW)) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .data_i         (data),
    .data_mod_i     (mod),
    .data_val_i     (val),
    .ser_data_o     (ser),
    .ser_data_val_o (ser_val),
    .busy_o         (busy)
  );

  typedef struct {
    logic          srst;
    logic          val;
    logic [DW-1:0] data;
    logic [MW-1:0] mod;
    logic          e_ser;
    logic          e_val;
    logic          e_busy;
  } vec_t;

  vec_t tbl [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic e_ser, input logic e_val, input logic e_busy);
    chk({name, ".ser"},  ser,     e_ser);
    chk({name, ".val"},  ser_val, e_val);
    chk({name, ".busy"}, busy,    e_busy);
  endtask

  // Checks len bits of w MSB first; returns while the last bit is still on the output
  task automatic serial_check(input string name, input logic [DW-1:0] w, input int len);
    for (int i = 0; i < len; i++) begin
      chk_out($sformatf("%s.b%0d", name, i), w[DW-1-i], 1'b1, PF ? 1'b0 : (i != len-1));
      if (i < len-1) step();
    end
  endtask

  initial begin
    logic [DW-1:0] w;

    //           srst  val   data      mod   ser   val   busy
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'hF000, 4'd3, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 16'h4000, 4'd2, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 16'h8000, 4'd1, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 16'h0000, 4'd1, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};

    step();
    for (int i = 0; i < 10; i++) begin
      srst = tbl[i].srst;
      val  = tbl[i].val;
      data = tbl[i].data;
      mod  = tbl[i].mod;
      step();
      chk_out($sformatf("tbl%0d", i), tbl[i].e_ser, tbl[i].e_val, PF ? 1'b0 : tbl[i].e_busy);
    end
    val = 1'b0;

    // Full 16-bit word from idle
    data = 16'hA5C3; mod = 4'd0; val = 1'b1;
    step();
    val = 1'b0;
    serial_check("a5c3", 16'hA5C3, 16);
    step();
    chk_out("a5c3.end", 1'b0, 1'b0, 1'b0);

    // Back-to-back: second word offered on the last-bit cycle
    data = 16'hFFFF; mod = 4'd0; val = 1'b1;
    step();
    val = 1'b0;
    serial_check("b2b1", 16'hFFFF, 16);
    data = 16'h0000; mod = 4'd0; val = 1'b1;
    step();
    val = 1'b0;
    serial_check("b2b2", 16'h0000, 16);
    step();
    chk_out("b2b.end", 1'b0, 1'b0, 1'b0);

`ifndef SERIALIZER_PREFETCH_EN
    // Offers while busy are dropped
    w = 16'h8421;
    data = w; mod = 4'd0; val = 1'b1;
    step();
    for (int k = 0; k < 15; k++) begin
      chk_out($sformatf("drop.b%0d", k), w[DW-1-k], 1'b1, 1'b1);
      val  = 1'b1;
      data = 16'h7BDE ^ DW'(k);
      mod  = MW'(k);
      step();
    end
    val = 1'b0;
    chk_out("drop.b15", w[0], 1'b1, 1'b0);
    step();
    chk_out("drop.end", 1'b0, 1'b0, 1'b0);
`endif

    // Reset mid-word (with a competing offer), then a clean word
    w = 16'hA5C3;
    data = w; mod = 4'd0; val = 1'b1;
    step();
    val = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      chk_out($sformatf("rst.b%0d", i), w[DW-1-i], 1'b1, PF ? 1'b0 : 1'b1);
      if (i < 5) step();
    end
    srst = 1'b1; val = 1'b1; data = 16'hFFFF;
    step();
    srst = 1'b0; val = 1'b0;
    chk_out("rst.after", 1'b0, 1'b0, 1'b0);
    step();
    chk_out("rst.after2", 1'b0, 1'b0, 1'b0);
    data = 16'h8001; mod = 4'd0; val = 1'b1;
    step();
    val = 1'b0;
    serial_check("8001", 16'h8001, 16);
    step();
    chk_out("8001.end", 1'b0, 1'b0, 1'b0);

`ifdef SERIALIZER_PREFETCH_EN
    // Second word prefetched at bit 2 of the first, handed over at the last-bit edge
    w = 16'hC003;
    data = w; mod = 4'd0; val = 1'b1;
    step();
    val = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("pf1.b%0d", i), w[DW-1-i], 1'b1, (i >= 3));
      if (i == 2) begin
        data = 16'h5A5A; mod = 4'd8; val = 1'b1;
      end else begin
        val = 1'b0;
      end
      if (i < 15) step();
    end
    step();
    serial_check("pf2", 16'h5A5A, 8);
    step();
    chk_out("pf.end", 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
